// File: rtl/bilinear_pkg.sv
// rtl/bilinear_pkg.sv - shared constants and weight-format helpers for bilinear_weight_gen
package bilinear_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  localparam logic MODE_BILINEAR = 1'b0;
  localparam logic MODE_NEAREST  = 1'b1;

  // Weights carry one integer bit so that 1.0 is representable exactly.
  function automatic int wgt_width(input int out_frac);
    return out_frac + 1;
  endfunction

  function automatic longint one_value(input int out_frac);
    return longint'(1) << out_frac;
  endfunction

endpackage

// File: rtl/bilw_round_scale.sv
// rtl/bilw_round_scale.sv - scales one corner product to weight format with rounding and saturation
module bilw_round_scale
  import bilinear_pkg::*;
#(
  parameter int FRAC_W     = 12,
  parameter int OUT_FRAC   = 12,
  parameter int ROUND_MODE = ROUND_HALF_UP
) (
  input  logic [2*FRAC_W+1:0]           prod,
  output logic [wgt_width(OUT_FRAC)-1:0] weight
);

  localparam int PW    = 2*FRAC_W + 2;
  localparam int SH    = 2*FRAC_W - OUT_FRAC;
  localparam int WGT_W = wgt_width(OUT_FRAC);
  localparam logic [PW:0] ONE_EXT = {{(PW-OUT_FRAC){1'b0}}, 1'b1, {OUT_FRAC{1'b0}}};

  logic [PW:0] shifted;
  logic [PW:0] rounded;

  assign shifted = {1'b0, prod} >> SH;

  generate
    if (ROUND_MODE == ROUND_HALF_UP && SH > 0) begin : g_round
      assign rounded = shifted + {{PW{1'b0}}, prod[SH-1]};
    end else begin : g_trunc
      assign rounded = shifted;
    end
  endgenerate

  assign weight = (rounded > ONE_EXT) ? ONE_EXT[WGT_W-1:0] : rounded[WGT_W-1:0];

endmodule

// File: rtl/bilinear_weight_gen.sv
// rtl/bilinear_weight_gen.sv - 3-stage bilinear/nearest corner weight generator with backpressure
// Optional macro BILW_SUM_CORRECT_EN forces bilinear weights to sum to exactly ONE.
module bilinear_weight_gen
  import bilinear_pkg::*;
#(
  parameter int FRAC_W     = 12,
  parameter int OUT_FRAC   = 12,
  parameter int ROUND_MODE = ROUND_HALF_UP,
  parameter int TAG_W      = 16,
  localparam int WGT_W     = wgt_width(OUT_FRAC)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              mode_i,
  input  logic [FRAC_W-1:0] u_i,
  input  logic [FRAC_W-1:0] v_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WGT_W-1:0]  w00_o,
  output logic [WGT_W-1:0]  w01_o,
  output logic [WGT_W-1:0]  w10_o,
  output logic [WGT_W-1:0]  w11_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int PW = 2*FRAC_W + 2;
  localparam logic [FRAC_W:0]  FULL = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [WGT_W-1:0] ONE  = WGT_W'(one_value(OUT_FRAC));

  logic en1, en2, en3;
  logic s1_valid, s1_mode;
  logic [FRAC_W-1:0] s1_u, s1_v;
  logic [FRAC_W:0]   s1_cu, s1_cv;
  logic [TAG_W-1:0]  s1_tag;
  logic s2_valid, s2_mode, s2_xi, s2_yi;
  logic [PW-1:0]     s2_p00, s2_p01, s2_p10, s2_p11;
  logic [TAG_W-1:0]  s2_tag;
  logic [WGT_W-1:0]  r00, r01, r10, r11;
  logic [WGT_W-1:0]  n00, n01, n10, n11;

  // A stage may load when it is empty or its successor is loading this cycle.
  assign en3         = !out_valid_o | out_ready_i;
  assign en2         = !s2_valid | en3;
  assign en1         = !s1_valid | en2;
  assign in_ready_o  = en1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_u     <= '0;
      s1_v     <= '0;
      s1_cu    <= '0;
      s1_cv    <= '0;
      s1_tag   <= '0;
    end else if (en1) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_mode <= mode_i;
        s1_u    <= u_i;
        s1_v    <= v_i;
        s1_cu   <= FULL - {1'b0, u_i};
        s1_cv   <= FULL - {1'b0, v_i};
        s1_tag  <= tag_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_xi    <= 1'b0;
      s2_yi    <= 1'b0;
      s2_p00   <= '0;
      s2_p01   <= '0;
      s2_p10   <= '0;
      s2_p11   <= '0;
      s2_tag   <= '0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode <= s1_mode;
        s2_xi   <= s1_u[FRAC_W-1];
        s2_yi   <= s1_v[FRAC_W-1];
        s2_p00  <= PW'(s1_cu) * PW'(s1_cv);
        s2_p01  <= PW'(s1_u)  * PW'(s1_cv);
        s2_p10  <= PW'(s1_cu) * PW'(s1_v);
        s2_p11  <= PW'(s1_u)  * PW'(s1_v);
        s2_tag  <= s1_tag;
      end
    end
  end

  bilw_round_scale #(.FRAC_W(FRAC_W), .OUT_FRAC(OUT_FRAC), .ROUND_MODE(ROUND_MODE))
    u_rs00 (.prod(s2_p00), .weight(r00));
  bilw_round_scale #(.FRAC_W(FRAC_W), .OUT_FRAC(OUT_FRAC), .ROUND_MODE(ROUND_MODE))
    u_rs01 (.prod(s2_p01), .weight(r01));
  bilw_round_scale #(.FRAC_W(FRAC_W), .OUT_FRAC(OUT_FRAC), .ROUND_MODE(ROUND_MODE))
    u_rs10 (.prod(s2_p10), .weight(r10));
  bilw_round_scale #(.FRAC_W(FRAC_W), .OUT_FRAC(OUT_FRAC), .ROUND_MODE(ROUND_MODE))
    u_rs11 (.prod(s2_p11), .weight(r11));

`ifdef BILW_SUM_CORRECT_EN
  logic [WGT_W+1:0] part_sum, one_ext, residual;
  assign part_sum = {2'b00, r00} + {2'b00, r01} + {2'b00, r10};
  assign one_ext  = {2'b00, ONE};
  assign residual = one_ext - part_sum;
`endif

  always_comb begin
    n00 = r00;
    n01 = r01;
    n10 = r10;
    n11 = r11;
    if (s2_mode == MODE_NEAREST) begin
      n00 = '0;
      n01 = '0;
      n10 = '0;
      n11 = '0;
      unique case ({s2_yi, s2_xi})
        2'b00:   n00 = ONE;
        2'b01:   n01 = ONE;
        2'b10:   n10 = ONE;
        default: n11 = ONE;
      endcase
    end else begin
`ifdef BILW_SUM_CORRECT_EN
      n11 = (part_sum > one_ext) ? '0 : residual[WGT_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      w00_o       <= '0;
      w01_o       <= '0;
      w10_o       <= '0;
      w11_o       <= '0;
      tag_o       <= '0;
    end else if (en3) begin
      out_valid_o <= s2_valid;
      if (s2_valid) begin
        w00_o <= n00;
        w01_o <= n01;
        w10_o <= n10;
        w11_o <= n11;
        tag_o <= s2_tag;
      end
    end
  end

endmodule
